// File: rtl/verilog_divider.sv
// verilog_divider: multi-cycle IEEE 754 single-precision divider, res = op1 / op2.
// Operands are flushed to zero when denormal, special cases resolve in four
// cycles, and normal quotients come from restoring division at one bit per
// clock (32 cycles from the ready edge to done).
// Optional feature macro: DIV_ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the quotient is truncated (latency is identical either way).
module verilog_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done
);

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_EVAL   = 4'd1,
        ST_CHECK  = 4'd2,
        ST_ALIGN  = 4'd3,
        ST_DIV    = 4'd4,
        ST_ROUND  = 4'd5,
        ST_RANGE  = 4'd6,
        ST_FINISH = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        TY_ZER = 2'd0,
        TY_NUM = 2'd1,
        TY_INF = 2'd2,
        TY_NAN = 2'd3
    } kind_t;

    state_t             state_reg, state_next;
    logic               sign1_reg, sign2_reg;
    logic [7:0]         exp1_reg, exp2_reg;
    logic [23:0]        man1_reg, man2_reg;
    kind_t              kind_reg;
    kind_t              eval_kind;
    logic signed [9:0]  e_reg;
    logic [25:0]        rem_reg;
    logic [24:0]        q_reg;
    logic [4:0]         cnt_reg;
    logic [23:0]        mant_reg;
    logic [25:0]        rem_diff;
    logic               round_inc;
    logic [24:0]        round_sum;

    // Flush-to-zero classification of one captured operand.
    function automatic kind_t classify(input logic [7:0] e, input logic [22:0] f);
        if (e == 8'hFF)
            return (f == 23'd0) ? TY_INF : TY_NAN;
        else if (e == 8'h00)
            return TY_ZER;
        else
            return TY_NUM;
    endfunction

    // Resolve the result type from both operand classes, highest priority first.
    always_comb begin
        kind_t k1;
        kind_t k2;
        k1 = classify(exp1_reg, man1_reg[22:0]);
        k2 = classify(exp2_reg, man2_reg[22:0]);
        eval_kind = TY_NUM;
        if (k1 == TY_NAN || k2 == TY_NAN ||
            (k1 == TY_ZER && k2 == TY_ZER) ||
            (k1 == TY_INF && k2 == TY_INF))
            eval_kind = TY_NAN;
        else if (k1 == TY_INF || k2 == TY_ZER)
            eval_kind = TY_INF;
        else if (k1 == TY_ZER || k2 == TY_INF)
            eval_kind = TY_ZER;
    end

    // Trial subtraction and rounding increment feeding the datapath.
    always_comb begin
        rem_diff  = rem_reg - {2'b00, man2_reg};
`ifdef DIV_ROUND_NEAREST_EN
        // q[0] is the guard bit; any leftover remainder is sticky.
        round_inc = q_reg[0] & ((|rem_reg) | q_reg[1]);
`else
        round_inc = 1'b0;
`endif
        round_sum = {1'b0, q_reg[24:1]} + {24'd0, round_inc};
    end

`ifndef DIV_ROUND_NEAREST_EN
    // Guard bit has no consumer when truncating.
    logic unused_guard;
    assign unused_guard = &{1'b0, q_reg[0]};
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ST_START;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = ST_START;
        case (state_reg)
            ST_START:  state_next = ready ? ST_EVAL : ST_START;
            ST_EVAL:   state_next = ST_CHECK;
            ST_CHECK:  state_next = (kind_reg == TY_NUM) ? ST_ALIGN : ST_FINISH;
            ST_ALIGN:  state_next = ST_DIV;
            ST_DIV:    state_next = (cnt_reg == 5'd24) ? ST_ROUND : ST_DIV;
            ST_ROUND:  state_next = ST_RANGE;
            ST_RANGE:  state_next = ST_FINISH;
            ST_FINISH: state_next = ST_START;
            default:   state_next = ST_START;
        endcase
    end

    // Datapath: capture, exponent, division, rounding, range check and packing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign1_reg <= 1'b0;
            sign2_reg <= 1'b0;
            exp1_reg  <= 8'd0;
            exp2_reg  <= 8'd0;
            man1_reg  <= 24'd0;
            man2_reg  <= 24'd0;
            kind_reg  <= TY_ZER;
            e_reg     <= 10'sd0;
            rem_reg   <= 26'd0;
            q_reg     <= 25'd0;
            cnt_reg   <= 5'd0;
            mant_reg  <= 24'd0;
            res       <= 32'd0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                ST_START: begin
                    sign1_reg <= op1[31];
                    sign2_reg <= op2[31];
                    exp1_reg  <= op1[30:23];
                    exp2_reg  <= op2[30:23];
                    man1_reg  <= {1'b1, op1[22:0]};
                    man2_reg  <= {1'b1, op2[22:0]};
                    done      <= 1'b0;
                end
                ST_EVAL: begin
                    kind_reg <= eval_kind;
                    e_reg    <= $signed({2'b00, exp1_reg}) - $signed({2'b00, exp2_reg}) + 10'sd127;
                end
                ST_ALIGN: begin
                    // Pre-shift a smaller dividend so the quotient lands in [1,2).
                    if (man1_reg < man2_reg) begin
                        rem_reg <= {1'b0, man1_reg, 1'b0};
                        e_reg   <= e_reg - 10'sd1;
                    end else begin
                        rem_reg <= {2'b00, man1_reg};
                    end
                    cnt_reg <= 5'd0;
                end
                ST_DIV: begin
                    if (rem_reg >= {2'b00, man2_reg}) begin
                        q_reg   <= {q_reg[23:0], 1'b1};
                        rem_reg <= {rem_diff[24:0], 1'b0};
                    end else begin
                        q_reg   <= {q_reg[23:0], 1'b0};
                        rem_reg <= {rem_reg[24:0], 1'b0};
                    end
                    cnt_reg <= (cnt_reg == 5'd24) ? 5'd0 : cnt_reg + 5'd1;
                end
                ST_ROUND: begin
                    if (round_sum[24]) begin
                        mant_reg <= 24'h800000;
                        e_reg    <= e_reg + 10'sd1;
                    end else begin
                        mant_reg <= round_sum[23:0];
                    end
                end
                ST_RANGE: begin
                    if (e_reg <= 10'sd0)
                        kind_reg <= TY_ZER;
                    else if (e_reg >= 10'sd255)
                        kind_reg <= TY_INF;
                    else
                        kind_reg <= TY_NUM;
                end
                ST_FINISH: begin
                    case (kind_reg)
                        TY_ZER:  res <= {sign1_reg ^ sign2_reg, 31'd0};
                        TY_INF:  res <= {sign1_reg ^ sign2_reg, 31'h7F800000};
                        TY_NAN:  res <= {sign1_reg ^ sign2_reg, 31'h7FFFFFFF};
                        default: res <= {sign1_reg ^ sign2_reg, e_reg[7:0], mant_reg[22:0]};
                    endcase
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
